mem_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port memory (valid/ready/wr_rd/addr/wdata/rdata protocol) between two masters.
- Latches the winning request, drives the memory port until the memory asserts ready, then returns a one-cycle ready pulse (and read data) to the winner.
- A watchdog aborts any memory access that does not complete in time.

---
 rtl/mem_rr_arbiter_if.sv | 58 +++++
 rtl/mem_rr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Signal bundle between the round-robin arbiter, its two requesters and the
// shared single-port memory. The arbiter connects through the slave modport;
// the environment (requesters plus memory) drives through the master modport.
//
// Handshake: a requester raises reqN_valid with a stable command and holds it
// until reqN_ready pulses for one cycle (reqN_err qualifies that pulse). On the
// memory side mem_valid stays high with a stable command until mem_ready is
// sampled high; at most one memory request is ever outstanding.
interface mem_rr_arbiter_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5
);
   // requester 0
   logic                  req0_valid;
   logic                  req0_wr_rd;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [WIDTH-1:0]      req0_wdata;
   logic                  req0_ready;
   logic [WIDTH-1:0]      req0_rdata;
   logic                  req0_err;

   // requester 1
   logic                  req1_valid;
   logic                  req1_wr_rd;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [WIDTH-1:0]      req1_wdata;
   logic                  req1_ready;
   logic [WIDTH-1:0]      req1_rdata;
   logic                  req1_err;

   // shared memory port
   logic                  mem_valid;
   logic                  mem_wr_rd;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic                  mem_ready;
   logic [WIDTH-1:0]      mem_rdata;

   // arbiter side
   modport slave (
      input  req0_valid, req0_wr_rd, req0_addr, req0_wdata,
      output req0_ready, req0_rdata, req0_err,
      input  req1_valid, req1_wr_rd, req1_addr, req1_wdata,
      output req1_ready, req1_rdata, req1_err,
      output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   // environment side (requesters and memory)
   modport master (
      output req0_valid, req0_wr_rd, req0_addr, req0_wdata,
      input  req0_ready, req0_rdata, req0_err,
      output req1_valid, req1_wr_rd, req1_addr, req1_wdata,
      input  req1_ready, req1_rdata, req1_err,
      input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port memory.
// The winning command is latched into registered mem_* outputs, held until
// the memory answers (or a watchdog expires), and completion is reported to
// the winner as a one-cycle ready pulse with registered read data.
// Every output is a flop; dbg_state exposes the FSM state for observation.
module mem_rr_arbiter #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 16   // BUSY cycles before abort, must be >= 2
) (
   input  logic                 clk,
   input  logic                 res,        // asynchronous, active low
   mem_rr_arbiter_if.slave      bus,
   output logic [1:0]           dbg_state
);

   // The counter only has to reach TIMEOUT-1.
   localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                state_q, state_d;

   // grant_q: requester owning the current transaction.
   // last_grant_q: requester served most recently; it loses the next tie.
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_wr_rd_q, mem_wr_rd_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;

   logic [1:0]            ready_q, ready_d;
   logic [1:0]            err_q, err_d;
   logic [WIDTH-1:0]      rdata0_q, rdata0_d;
   logic [WIDTH-1:0]      rdata1_q, rdata1_d;

   // Arbitration decode, only acted upon in IDLE.
   logic                  any_valid;
   logic                  winner;
   logic                  sel_wr_rd;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_wdata;

   // Completion conditions while BUSY; mem_ready wins over the watchdog.
   logic                  mem_done;
   logic                  wd_expired;

   // Pick the winner: a lone requester wins; on a tie the one not served last.
   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = bus.req1_valid;
      end
      if (winner) begin
         sel_wr_rd = bus.req1_wr_rd;
         sel_addr  = bus.req1_addr;
         sel_wdata = bus.req1_wdata;
      end else begin
         sel_wr_rd = bus.req0_wr_rd;
         sel_addr  = bus.req0_addr;
         sel_wdata = bus.req0_wdata;
      end
   end

   // Decode how a BUSY cycle ends.
   always_comb begin
      mem_done   = bus.mem_ready;
      wd_expired = ~bus.mem_ready && (cnt_q == CNT_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE always returns to IDLE so requests are never
   // sampled while a ready pulse is on the wire.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_done || wd_expired) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: next values of every registered output and the
   // arbitration bookkeeping. Ready/err default low, which makes them pulses.
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_valid_d  = mem_valid_q;
      mem_wr_rd_d  = mem_wr_rd_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ready_d      = 2'b00;
      err_d        = 2'b00;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               grant_d     = winner;
               mem_valid_d = 1'b1;
               mem_wr_rd_d = sel_wr_rd;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               cnt_d       = '0;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + CNT_ONE;
            if (mem_done) begin
               mem_valid_d       = 1'b0;
               ready_d[grant_q]  = 1'b1;
               last_grant_d      = grant_q;
               // Only reads refresh the winner's data register.
               if (!mem_wr_rd_q) begin
                  if (grant_q) begin
                     rdata1_d = bus.mem_rdata;
                  end else begin
                     rdata0_d = bus.mem_rdata;
                  end
               end
            end else if (wd_expired) begin
               mem_valid_d      = 1'b0;
               ready_d[grant_q] = 1'b1;
               err_d[grant_q]   = 1'b1;
               last_grant_d     = grant_q;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers; reset leaves requester 0 with first priority.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         mem_valid_q  <= 1'b0;
         mem_wr_rd_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ready_q      <= 2'b00;
         err_q        <= 2'b00;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_valid_q  <= mem_valid_d;
         mem_wr_rd_q  <= mem_wr_rd_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         ready_q      <= ready_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_wr_rd  = mem_wr_rd_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.req0_ready = ready_q[0];
   assign bus.req0_err   = err_q[0];
   assign bus.req0_rdata = rdata0_q;
   assign bus.req1_ready = ready_q[1];
   assign bus.req1_err   = err_q[1];
   assign bus.req1_rdata = rdata1_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a memory model answers mem requests,
// driver tasks play the two requesters, and a monitor compares every ready
// pulse against an expected queue of {requester, err, rdata} entries.
module tb_mem_rr_arbiter;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 32;
   localparam int AW      = 5;
   localparam int TIMEOUT = 16;
   localparam int EW      = WIDTH + 2;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [1:0] dbg_state;

   mem_rr_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   mem_rr_arbiter #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .res(res),
      .bus(bus.slave),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int              checks = 0;
   int              errors = 0;
   logic [EW-1:0]   exp_q[$];
   logic [WIDTH-1:0] last_rd [2];
   logic [WIDTH-1:0] mem_arr [DEPTH];
   logic [WIDTH-1:0] sweep_data [DEPTH];
   logic             stall_mem = 1'b0;

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] ent(input logic id, input logic err, input logic [WIDTH-1:0] d);
      return {id, err, d};
   endfunction

   // ---------------- memory model ----------------
   // One cycle after seeing a request it answers with mem_ready for one cycle.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
   end

   always @(posedge clk) begin
      if (bus.mem_valid && !bus.mem_ready && !stall_mem) begin
         bus.mem_ready <= 1'b1;
         bus.mem_rdata <= mem_arr[bus.mem_addr];
         if (bus.mem_wr_rd) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      end else begin
         bus.mem_ready <= 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input int id, input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      if (id == 0) begin
         bus.req0_valid = 1'b1; bus.req0_wr_rd = wr; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_wr_rd = wr; bus.req1_addr = a; bus.req1_wdata = d;
      end
   endtask

   task automatic drop(input int id);
      if (id == 0) bus.req0_valid = 1'b0;
      else         bus.req1_valid = 1'b0;
   endtask

   task automatic wait_ready(input int id);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = (id == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout_req%0d actual=no_ready required=ready", id);
      end
   endtask

   task automatic xact(input int id, input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      issue(id, wr, a, d);
      wait_ready(id);
      drop(id);
   endtask

   task automatic clear_last_rd();
      last_rd[0] = '0;
      last_rd[1] = '0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0]    e;
      logic [1:0]       rdy;
      logic [1:0]       er;
      logic [WIDTH-1:0] rd [2];
      rdy   = {bus.req1_ready, bus.req0_ready};
      er    = {bus.req1_err, bus.req0_err};
      rd[0] = bus.req0_rdata;
      rd[1] = bus.req1_rdata;
      if (res) begin
         for (int g = 0; g < 2; g++) begin
            if (rdy[g]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ready_req%0d actual=1 required=0", g);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_requester", 32'(g), 32'(e[EW-1]));
                  check("resp_err", 32'(er[g]), 32'(e[EW-2]));
                  check("resp_rdata", 32'(rd[g]), 32'(e[WIDTH-1:0]));
                  last_rd[g] = e[WIDTH-1:0];
                  check("other_rdata_kept", 32'(rd[1-g]), 32'(last_rd[1-g]));
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int   vcnt;
      logic seen;
      int   n;

      bus.req0_valid = 0; bus.req0_wr_rd = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 0; bus.req1_wr_rd = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
      clear_last_rd();

      // Reset state
      res = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      check("rst_mem_wr_rd", 32'(bus.mem_wr_rd), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check("rst_err", 32'({bus.req1_err, bus.req0_err}), 32'd0);
      check("rst_rdata0", 32'(bus.req0_rdata), 32'd0);
      check("rst_rdata1", 32'(bus.req1_rdata), 32'd0);
      res = 1'b1;
      @(negedge clk);

      // Single write then read-back by requester 0
      exp_q.push_back(ent(1'b0, 1'b0, 8'h00));
      issue(0, 1'b1, 5'd15, 8'hA5);
      check("t1_mem_valid_pre", 32'(bus.mem_valid), 32'd0);
      @(posedge clk);
      #1;
      check("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
      check("t1_mem_addr", 32'(bus.mem_addr), 32'd15);
      check("t1_mem_wr_rd", 32'(bus.mem_wr_rd), 32'd1);
      check("t1_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
      check("t1_state_busy", 32'(dbg_state), 32'd1);
      wait_ready(0);
      drop(0);
      exp_q.push_back(ent(1'b0, 1'b0, 8'hA5));
      xact(0, 1'b0, 5'd15, 8'h00);
      repeat (2) @(negedge clk);

      // Contention from reset: grants 0,1,0,1
      res = 1'b0;
      clear_last_rd();
      repeat (2) @(negedge clk);
      res = 1'b1;
      exp_q.push_back(ent(1'b0, 1'b0, 8'h00));
      exp_q.push_back(ent(1'b1, 1'b0, 8'h00));
      exp_q.push_back(ent(1'b0, 1'b0, 8'h11));
      exp_q.push_back(ent(1'b1, 1'b0, 8'h22));
      fork
         begin
            xact(0, 1'b1, 5'd3, 8'h11);
            xact(0, 1'b0, 5'd3, 8'h00);
         end
         begin
            xact(1, 1'b1, 5'd4, 8'h22);
            xact(1, 1'b0, 5'd4, 8'h00);
         end
      join
      repeat (2) @(negedge clk);

      // Sweep: requester 1 writes every address
      for (int i = 0; i < DEPTH; i++) begin
         sweep_data[i] = WIDTH'($urandom_range(0, 255));
         exp_q.push_back(ent(1'b1, 1'b0, 8'h22));
         xact(1, 1'b1, AW'(i), sweep_data[i]);
      end
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("sweep_mem_%0d", i), 32'(mem_arr[i]), 32'(sweep_data[i]));
      end

      // Watchdog: memory never answers
      stall_mem = 1'b1;
      exp_q.push_back(ent(1'b0, 1'b1, 8'h11));
      issue(0, 1'b0, 5'd7, 8'h00);
      vcnt = 0;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.mem_valid) vcnt++;
         seen = bus.req0_ready;
      end
      check("to_ready_seen", 32'(seen), 32'd1);
      check("to_mem_valid_cycles", 32'(vcnt), 32'(TIMEOUT));
      drop(0);
      stall_mem = 1'b0;
      exp_q.push_back(ent(1'b0, 1'b0, sweep_data[15]));
      xact(0, 1'b0, 5'd15, 8'h00);
      repeat (2) @(negedge clk);

      // Reset while BUSY, then requester 0 must win the tie
      stall_mem = 1'b1;
      issue(1, 1'b1, 5'd9, 8'h5C);
      n = 0;
      while (!bus.mem_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_busy_mem_valid", 32'(bus.mem_valid), 32'd1);
      #2;
      res = 1'b0;
      clear_last_rd();
      #1;
      check("async_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      check("async_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("async_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("async_rst_mem_wr_rd", 32'(bus.mem_wr_rd), 32'd0);
      check("async_rst_rdata0", 32'(bus.req0_rdata), 32'd0);
      check("async_rst_rdata1", 32'(bus.req1_rdata), 32'd0);
      check("async_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      stall_mem = 1'b0;
      exp_q.push_back(ent(1'b0, 1'b0, sweep_data[20]));
      exp_q.push_back(ent(1'b1, 1'b0, 8'h00));
      issue(0, 1'b0, 5'd20, 8'h00);
      res = 1'b1;
      fork
         begin
            wait_ready(0);
            drop(0);
         end
         begin
            wait_ready(1);
            drop(1);
         end
      join
      @(negedge clk);
      check("post_rst_mem9", 32'(mem_arr[9]), 32'h5C);

      // Abandoned request: requester 1 pulses valid only while 0 is BUSY
      exp_q.push_back(ent(1'b0, 1'b0, sweep_data[20]));
      issue(0, 1'b1, 5'd2, 8'h77);
      @(negedge clk);
      issue(1, 1'b0, 5'd5, 8'h00);
      @(negedge clk);
      drop(1);
      wait_ready(0);
      drop(0);
      repeat (10) @(negedge clk);
      check("abandon_mem2", 32'(mem_arr[2]), 32'h77);
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);
      check("end_state_idle", 32'(dbg_state), 32'd0);
      check("end_mem_valid", 32'(bus.mem_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
